sync_tx: RTL and testbench
==========================

Name: sync_tx

Overview:
Transmit-side counterpart of the circuito12 sync receiver. Drives the k/j/en line triple that circuito12 samples on its k, j and rx_en inputs.
- On a start request: sends a SYNC pattern, then an NRZI-encoded payload word (LSB first), then a single-symbol end-of-packet (SE0), then returns to idle.
- Used as the functional stimulus source for the receiver and as a loopback partner in BIST runs.

Parameters:
SYNC_LEN, 8, number of SYNC symbols; must be even and >= 2
DATA_W, 8, payload width in bits
BIT_DIV, 1, clock cycles per line symbol; must be >= 1

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-low reset
start  input  1  transmit request, sampled in IDLE only
data_in  input  DATA_W  payload; latched on the cycle start is accepted
busy  output  1  high while a packet is in flight
done  output  1  one-cycle pulse after EOP completes
k  output  1  K line state
j  output  1  J line state
tx_en  output  1  line driven; connects to receiver rx_en

Behaviour:
- Clocking and reset: one clock (CLK). RST is asynchronous and active-low. While RST=0, all outputs are 0 (busy, done, k, j, tx_en) and the FSM is in IDLE.
- Reset mid-packet aborts the packet immediately. No EOP is sent.
- Line encoding:
  - tx_en=0: k=j=0.
  - tx_en=1 carrying data: exactly one of k/j is 1.
  - SE0: tx_en=1, k=j=0.
- Symbol timing: each symbol holds BIT_DIV cycles, controlled by a divider counter that resets at every symbol boundary.
- FSM states: IDLE, SYNC, DATA, EOP, DONE.
- IDLE:
  - Outputs are 0.
  - If start=1 on a rising edge: latch data_in, clear the symbol index, go to SYNC.
  - The first SYNC symbol appears on the cycle after start is accepted (latency 1).
  - busy=1 from that same cycle.
- SYNC:
  - Symbol i (0..SYNC_LEN-1) is K if i is even or i == SYNC_LEN-1; otherwise it is J.
  - SYNC_LEN=8 gives K J K J K J K K.
  - After the last symbol, go to DATA.
- DATA:
  - Line state starts at K (the last SYNC symbol).
  - Bits are sent LSB first, NRZI: bit 0 toggles the line state (K<->J); bit 1 holds it.
  - After DATA_W bits, go to EOP.
- EOP: one symbol of SE0, then DONE.
- DONE:
  - Exactly one cycle.
  - Outputs: done=1, busy=0, tx_en=0, k=j=0.
  - Then go to IDLE.
  - A new start is accepted on the following IDLE cycle at the earliest.
- start while busy, or during the DONE cycle, is ignored and not queued.
- Changes on data_in after latching have no effect on the packet in flight.
- Packet length without stuffing: SYNC_LEN + DATA_W + 1 symbols. Packet duration is that times BIT_DIV cycles.
- The symbol index and bit counter are wide enough for max(SYNC_LEN, DATA_W) with no wrap.

Optional Feature:
SYNC_TX_BITSTUFF_EN
- Defined:
  - A ones-run counter, cleared at entry to DATA, counts consecutive 1 data bits.
  - When it reaches 6, a stuffed symbol (line toggle) is inserted before the next data bit and the counter clears.
  - This applies even when the 6th one is the last data bit; the stuffed symbol then precedes EOP.
  - A 0 data bit also clears the counter.
  - Stuffed symbols last BIT_DIV cycles like any other symbol.
- Undefined: no stuffing logic is present. The ones-run counter is not synthesized.

Test Plan:
- Reset: hold RST=0 for 3 cycles while driving start=1 -> busy=done=k=j=tx_en=0 throughout. First start after release is accepted normally.
- Defaults, data_in=0x00:
  - Line per cycle: K J K J K J K K | J K J K J K J K | SE0.
  - tx_en=1 for 17 cycles; done pulses on cycle 18 after acceptance.
- data_in=0xFF, stuffing undefined: 8 SYNC symbols, then K x8, then SE0, 17 symbols total.
- data_in=0xFF with SYNC_TX_BITSTUFF_EN: 8 SYNC symbols, then K x6, J (stuffed), J J, then SE0, 18 symbols. done on cycle 19.
- BIT_DIV=3, data_in=0xA5:
  - Every symbol held exactly 3 cycles.
  - Payload symbols (LSB first, bits 1 0 1 0 0 1 0 1) are K J J K J J K K.
  - A start pulse mid-packet is ignored.
  - busy stays 1 for 51 cycles.
- Reset mid-DATA (assert RST after payload bit 3) -> outputs 0 asynchronously, no done pulse. After release, a new start transmits a full, correct packet.

Source files
------------

// File: rtl/sync_tx.sv
// sync_tx: drives the k/j/tx_en line triple: SYNC pattern, NRZI payload (LSB first), SE0 EOP.
// Optional bit stuffing after six consecutive ones: define SYNC_TX_BITSTUFF_EN.
module sync_tx #(
  parameter int SYNC_LEN = 8,
  parameter int DATA_W   = 8,
  parameter int BIT_DIV  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              k,
  output logic              j,
  output logic              tx_en
);

  localparam int MAX_N = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
  localparam int IDX_W = $clog2(MAX_N + 1);
  localparam int DIV_W = $clog2(BIT_DIV + 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   data_sh;
  logic                lvl;       // current data line level, 1 = K
  logic                sym_end, sync_last, data_last, nxt_bit, go_stuff;

  assign sym_end   = (div_cnt == DIV_W'(BIT_DIV - 1));
  assign sync_last = (idx == IDX_W'(SYNC_LEN - 1));
  assign data_last = (idx == IDX_W'(DATA_W - 1));

  generate
    if (DATA_W > 1) begin : g_nxt
      assign nxt_bit = data_sh[1];
    end else begin : g_nxt1
      assign nxt_bit = 1'b0;
    end
  endgenerate

`ifdef SYNC_TX_BITSTUFF_EN
  logic [2:0] ones_cnt;
  logic       stuff_q;    // current DATA symbol is a stuffed toggle

  assign go_stuff = (state == S_DATA) && !stuff_q && (ones_cnt == 3'd6);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ones_cnt <= '0;
      stuff_q  <= 1'b0;
    end else if (sym_end) begin
      if (state == S_SYNC && sync_last) begin
        ones_cnt <= data_sh[0] ? 3'd1 : 3'd0;
        stuff_q  <= 1'b0;
      end else if (state == S_DATA) begin
        if (go_stuff) begin
          ones_cnt <= '0;
          stuff_q  <= 1'b1;
        end else begin
          stuff_q <= 1'b0;
          if (!data_last) ones_cnt <= nxt_bit ? ones_cnt + 3'd1 : 3'd0;
        end
      end
    end
  end
`else
  assign go_stuff = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    k         = 1'b0;
    j         = 1'b0;
    tx_en     = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_SYNC;
      S_SYNC: begin
        busy  = 1'b1;
        tx_en = 1'b1;
        // even symbols and the final one are K
        k     = ~idx[0] | sync_last;
        j     = ~k;
        if (sym_end && sync_last) state_nxt = S_DATA;
      end
      S_DATA: begin
        busy  = 1'b1;
        tx_en = 1'b1;
        k     = lvl;
        j     = ~lvl;
        if (sym_end && !go_stuff && data_last) state_nxt = S_EOP;
      end
      S_EOP: begin
        busy  = 1'b1;
        tx_en = 1'b1;
        if (sym_end) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_cnt <= '0;
      idx     <= '0;
      data_sh <= '0;
      lvl     <= 1'b1;
    end else begin
      div_cnt <= (state == S_IDLE || state == S_DONE || sym_end) ? '0 : div_cnt + 1'b1;
      case (state)
        S_IDLE: if (start) begin
          data_sh <= data_in;
          idx     <= '0;
        end
        S_SYNC: if (sym_end) begin
          if (sync_last) begin
            idx <= '0;
            // line sits at K; first bit 0 toggles to J
            lvl <= data_sh[0];
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DATA: if (sym_end) begin
          if (go_stuff) begin
            lvl <= ~lvl;
          end else if (!data_last) begin
            idx     <= idx + 1'b1;
            data_sh <= data_sh >> 1;
            lvl     <= nxt_bit ? lvl : ~lvl;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_tx.sv
// Scoreboard bench for sync_tx: hand-written symbol strings are queued per packet, monitors pop per cycle.
module tb_sync_tx;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start1 = 1'b0, start3 = 1'b0;
  logic [7:0] d1 = '0, d3 = '0;
  logic       busy1, done1, k1, j1, tx_en1;
  logic       busy3, done3, k3, j3, tx_en3;

  int  errors = 0;
  int  checks = 0;
  int  busy3_cnt = 0;
  byte q1[$];
  byte q3[$];
  byte c1, c3;

`ifdef SYNC_TX_BITSTUFF_EN
  localparam string PKT_FF = "KJKJKJKKKKKKKKJJJE";
  localparam string PKT_3F = "KJKJKJKKKKKKKKJKJE";
`else
  localparam string PKT_FF = "KJKJKJKKKKKKKKKKE";
  localparam string PKT_3F = "KJKJKJKKKKKKKKJKE";
`endif

  sync_tx #(.SYNC_LEN(8), .DATA_W(8), .BIT_DIV(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .start(start1), .data_in(d1),
    .busy(busy1), .done(done1), .k(k1), .j(j1), .tx_en(tx_en1)
  );

  sync_tx #(.SYNC_LEN(8), .DATA_W(8), .BIT_DIV(3)) u_dut3 (
    .CLK(CLK), .RST(RST), .start(start3), .data_in(d3),
    .busy(busy3), .done(done3), .k(k3), .j(j3), .tx_en(tx_en3)
  );

  always #5 CLK = ~CLK;

  // {busy, done, tx_en, k, j}
  function automatic logic [4:0] enc(input byte c);
    case (c)
      "K":     return 5'b10110;
      "J":     return 5'b10101;
      "E":     return 5'b10100;
      "D":     return 5'b01000;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (busy,done,tx_en,k,j) at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int sel, input string s, input int div);
    for (int i = 0; i < s.len(); i++)
      for (int r = 0; r < div; r++)
        if (sel == 1) q1.push_back(s[i]); else q3.push_back(s[i]);
    if (sel == 1) q1.push_back("D"); else q3.push_back("D");
  endtask

  task automatic wait_drain(input int sel, input string name);
    int n;
    n = 0;
    while (((sel == 1) ? q1.size() : q3.size()) != 0 && n < 300) begin
      @(posedge CLK);
      n++;
    end
    chk_int({name, "_drain_timeout"}, (n >= 300) ? 1 : 0, 0);
    repeat (3) @(posedge CLK);
  endtask

  task automatic send1(input logic [7:0] d, input string s);
    @(posedge CLK); #1;
    d1 = d;
    start1 = 1'b1;
    push(1, s, 1);
    @(posedge CLK); #1;
    start1 = 1'b0;
    d1 = ~d;
  endtask

  always @(negedge CLK) begin
    if (RST === 1'b1 && (busy1 || done1 || tx_en1 || k1 || j1)) begin
      if (q1.size() == 0) chk("dut1_unexpected", {busy1, done1, tx_en1, k1, j1}, 5'b0);
      else begin
        c1 = q1.pop_front();
        chk("dut1_line", {busy1, done1, tx_en1, k1, j1}, enc(c1));
      end
    end
  end

  always @(negedge CLK) begin
    if (RST === 1'b1 && busy3) busy3_cnt++;
    if (RST === 1'b1 && (busy3 || done3 || tx_en3 || k3 || j3)) begin
      if (q3.size() == 0) chk("dut3_unexpected", {busy3, done3, tx_en3, k3, j3}, 5'b0);
      else begin
        c3 = q3.pop_front();
        chk("dut3_line", {busy3, done3, tx_en3, k3, j3}, enc(c3));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    // reset held with start asserted
    start1 = 1'b1; start3 = 1'b1; d1 = 8'hFF; d3 = 8'hFF;
    repeat (3) begin
      @(posedge CLK); #1;
      chk("reset_dut1", {busy1, done1, tx_en1, k1, j1}, 5'b0);
      chk("reset_dut3", {busy3, done3, tx_en3, k3, j3}, 5'b0);
    end
    start1 = 1'b0; start3 = 1'b0;
    RST = 1'b1;

    send1(8'h00, "KJKJKJKKJKJKJKJKE");
    wait_drain(1, "pkt_00");
    send1(8'hFF, PKT_FF);
    wait_drain(1, "pkt_ff");
    send1(8'h3F, PKT_3F);
    wait_drain(1, "pkt_3f");

    // start asserted only during the DONE cycle is dropped
    send1(8'h00, "KJKJKJKKJKJKJKJKE");
    n = 0;
    while (!done1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk_int("done_wait_timeout", (n >= 100) ? 1 : 0, 0);
    start1 = 1'b1;
    @(posedge CLK); #1;
    start1 = 1'b0;
    repeat (4) @(posedge CLK);
    wait_drain(1, "pkt_done_start");

    // BIT_DIV=3 with a mid-packet start and data change
    @(posedge CLK); #1;
    d3 = 8'hA5;
    start3 = 1'b1;
    push(3, "KJKJKJKKKJJKJJKKE", 3);
    @(posedge CLK); #1;
    start3 = 1'b0;
    d3 = 8'h00;
    repeat (20) @(posedge CLK);
    #1;
    start3 = 1'b1;
    d3 = 8'hFF;
    @(posedge CLK); #1;
    start3 = 1'b0;
    wait_drain(3, "pkt_a5_div3");
    repeat (5) @(posedge CLK);
    chk_int("busy_cycles_div3", busy3_cnt, 51);

    // reset in the middle of the payload
    @(posedge CLK); #1;
    d1 = 8'h5A;
    start1 = 1'b1;
    push(1, "KJKJKJKKJJKKKJJKE", 1);
    @(posedge CLK); #1;
    start1 = 1'b0;
    repeat (12) @(posedge CLK);
    #1;
    chk_int("symbols_before_abort", q1.size(), 6);
    RST = 1'b0;
    q1.delete();
    #1;
    chk("abort_async", {busy1, done1, tx_en1, k1, j1}, 5'b0);
    repeat (2) @(posedge CLK);
    #1;
    chk("abort_held", {busy1, done1, tx_en1, k1, j1}, 5'b0);
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    send1(8'h3C, "KJKJKJKKJKKKKKJKE");
    wait_drain(1, "pkt_3c_after_abort");

    chk_int("q1_empty", q1.size(), 0);
    chk_int("q3_empty", q3.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
